// File: rtl/tx_len_stream.sv
// tx_len_stream: collects a little-endian length header, then packs that many payload bytes into DW_BYTES-wide beats.
// Build option TX_LEN_STREAM_PATTERN_EN replaces the sample stream with an internal byte-counter payload source.
module tx_len_stream #(
    parameter int unsigned DW_BYTES  = 4,
    parameter int unsigned LEN_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  i_tready,
    input  logic                  i_tvalid,
    input  logic [7:0]            i_tdata,
    output logic                  s_tready,
    input  logic                  s_tvalid,
    input  logic [7:0]            s_tdata,
    input  logic                  o_tready,
    output logic                  o_tvalid,
    output logic [8*DW_BYTES-1:0] o_tdata,
    output logic [DW_BYTES-1:0]   o_tkeep,
    output logic                  o_tlast,
    output logic                  busy
);
    localparam int unsigned LW  = 8 * LEN_BYTES;
    localparam int unsigned DW  = 8 * DW_BYTES;
    localparam int unsigned HCW = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
    localparam int unsigned PCW = $clog2(DW_BYTES + 1);

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_PACK = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [HCW-1:0]      hcnt_q, hcnt_d;
    logic [LW-1:0]       hdr_q, hdr_d;
    logic [LW-1:0]       rem_q, rem_d;
    logic [PCW-1:0]      pcnt_q, pcnt_d;
    logic [DW-1:0]       data_q, data_d;
    logic [DW_BYTES-1:0] keep_q, keep_d;
    logic                last_q, last_d;
    logic                valid_q, valid_d;

    logic                hdr_fire_c;
    logic                hdr_done_c;
    logic                out_fire_c;
    logic                pack_done_c;
    logic [LW-1:0]       len_c;

    assign hdr_fire_c = i_tvalid & i_tready;
    assign hdr_done_c = hdr_fire_c && (hcnt_q == HCW'(LEN_BYTES - 1));
    assign out_fire_c = valid_q & o_tready;

    // Header value with the byte currently on i_tdata merged into its slot.
    always_comb begin
        len_c = hdr_q;
        for (int unsigned k = 0; k < LEN_BYTES; k++) begin
            if (HCW'(k) == hcnt_q) len_c[8*k +: 8] = i_tdata;
        end
    end

`ifdef TX_LEN_STREAM_PATTERN_EN
    logic [7:0]     pat_q, pat_d;
    logic [PCW-1:0] fill_n_c;
    logic           unused_s;

    assign fill_n_c    = (rem_q < LW'(DW_BYTES)) ? PCW'(rem_q) : PCW'(DW_BYTES);
    assign pack_done_c = 1'b1;
    assign unused_s    = ^{s_tvalid, s_tdata};
`else
    logic smp_fire_c;

    assign smp_fire_c  = s_tvalid & s_tready;
    assign pack_done_c = smp_fire_c && ((pcnt_q == PCW'(DW_BYTES - 1)) || (rem_q == LW'(1)));
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_HDR;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HDR:  if (hdr_done_c && (len_c != '0)) state_d = ST_PACK;
            ST_PACK: if (pack_done_c) state_d = ST_SEND;
            ST_SEND: if (out_fire_c) state_d = last_q ? ST_HDR : ST_PACK;
            default: state_d = ST_HDR;
        endcase
    end

    // Ready/busy decoded from registered state only
    always_comb begin
        i_tready = (state_q == ST_HDR);
        busy     = (state_q != ST_HDR);
`ifdef TX_LEN_STREAM_PATTERN_EN
        s_tready = 1'b0;
`else
        s_tready = (state_q == ST_PACK);
`endif
    end

    // Datapath next-state
    always_comb begin
        hcnt_d  = hcnt_q;
        hdr_d   = hdr_q;
        rem_d   = rem_q;
        pcnt_d  = pcnt_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q;
`ifdef TX_LEN_STREAM_PATTERN_EN
        pat_d   = pat_q;
`endif
        case (state_q)
            ST_HDR: begin
                if (hdr_fire_c) begin
                    if (hdr_done_c) begin
                        hcnt_d = '0;
                        hdr_d  = '0;
                        rem_d  = len_c;
`ifdef TX_LEN_STREAM_PATTERN_EN
                        pat_d  = 8'd0;
`endif
                    end else begin
                        hcnt_d = hcnt_q + HCW'(1);
                        hdr_d  = len_c;
                    end
                end
            end
            ST_PACK: begin
`ifdef TX_LEN_STREAM_PATTERN_EN
                // Whole beat (or the tail) is filled in one cycle
                for (int unsigned k = 0; k < DW_BYTES; k++) begin
                    if (PCW'(k) < fill_n_c) begin
                        data_d[8*k +: 8] = pat_q + 8'(k);
                        keep_d[k]        = 1'b1;
                    end
                end
                pat_d   = pat_q + 8'(fill_n_c);
                rem_d   = rem_q - LW'(fill_n_c);
                pcnt_d  = fill_n_c;
                last_d  = (rem_q == LW'(fill_n_c));
                valid_d = 1'b1;
`else
                if (smp_fire_c) begin
                    for (int unsigned k = 0; k < DW_BYTES; k++) begin
                        if (PCW'(k) == pcnt_q) begin
                            data_d[8*k +: 8] = s_tdata;
                            keep_d[k]        = 1'b1;
                        end
                    end
                    pcnt_d = pcnt_q + PCW'(1);
                    rem_d  = rem_q - LW'(1);
                    if (pack_done_c) begin
                        last_d  = (rem_q == LW'(1));
                        valid_d = 1'b1;
                    end
                end
`endif
            end
            ST_SEND: begin
                // Clearing on accept keeps unwritten lanes of the next beat at zero
                if (out_fire_c) begin
                    pcnt_d  = '0;
                    data_d  = '0;
                    keep_d  = '0;
                    last_d  = 1'b0;
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q  <= '0;
            hdr_q   <= '0;
            rem_q   <= '0;
            pcnt_q  <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef TX_LEN_STREAM_PATTERN_EN
            pat_q   <= 8'd0;
`endif
        end else begin
            hcnt_q  <= hcnt_d;
            hdr_q   <= hdr_d;
            rem_q   <= rem_d;
            pcnt_q  <= pcnt_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
`ifdef TX_LEN_STREAM_PATTERN_EN
            pat_q   <= pat_d;
`endif
        end
    end

    assign o_tvalid = valid_q;
    assign o_tdata  = data_q;
    assign o_tkeep  = keep_q;
    assign o_tlast  = last_q;

endmodule
